vred_seq_ctrl: RTL

Sequencer that owns the integer reduction pipeline (vredsum/vredmin[u]/vredmax[u]). Accepts one reduction command at a time and reads vs2 from the register file at a fixed read latency. Drives the pipeline with gap-free valid/start/end beats, masks tail elements with the op identity, and forwards the single pipeline result as a write-back.

---
 rtl/vred_pkg.sv | 42 ++++
 rtl/vred_tail_mask.sv | 25 ++
 rtl/vred_seq_ctrl.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/vred_pkg.sv
// Shared opsel constants, SEW/FSM types and the tail identity helper for the
// integer reduction sequencer.
package vred_pkg;

    localparam logic [4:0] REDSUM  = 5'b00000;
    localparam logic [4:0] REDMINU = 5'b00100;
    localparam logic [4:0] REDMIN  = 5'b00101;
    localparam logic [4:0] REDMAXU = 5'b00110;
    localparam logic [4:0] REDMAX  = 5'b00111;

    typedef enum logic [1:0] {
        SEW8  = 2'd0,
        SEW16 = 2'd1,
        SEW32 = 2'd2,
        SEW64 = 2'd3
    } sew_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Identity element of the op, replicated across every SEW lane of a beat.
    function automatic logic [63:0] identity(input logic [4:0] opsel, input logic [1:0] sew);
        logic [63:0] msb_rep;
        case (sew)
            2'd0:    msb_rep = {8{8'h80}};
            2'd1:    msb_rep = {4{16'h8000}};
            2'd2:    msb_rep = {2{32'h8000_0000}};
            default: msb_rep = {1'b1, 63'd0};
        endcase
        case (opsel)
            REDMINU: identity = '1;
            REDMAX:  identity = msb_rep;
            REDMIN:  identity = ~msb_rep;
            default: identity = '0;
        endcase
    endfunction

endpackage

// File: rtl/vred_tail_mask.sv
// Replaces elements at or beyond the active count in the final beat with the
// op identity. vl_rem == 0 means the beat is fully populated.
module vred_tail_mask
    import vred_pkg::*;
(
    input  logic [63:0] beat,
    input  logic [2:0]  vl_rem,
    input  logic [1:0]  sew,
    input  logic [4:0]  opsel,
    output logic [63:0] masked
);

    logic [63:0] ident;

    always_comb begin
        ident  = identity(opsel, sew);
        masked = beat;
        for (int b = 0; b < 8; b++) begin
            if ((vl_rem != 3'd0) && ((3'(b) >> sew) >= vl_rem)) begin
                masked[b*8 +: 8] = ident[b*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/vred_seq_ctrl.sv
// Reduction sequencer: reads vs2 beats, drives gap-free pipeline beats with
// tail masking, and registers the pipeline result as a write-back.
// Optional performance counters are built when VRED_SEQ_PERF_EN is defined.
module vred_seq_ctrl
    import vred_pkg::*;
#(
    parameter int DATA_WIDTH  = 64,
    parameter int ADDR_WIDTH  = 32,
    parameter int VL_WIDTH    = 11,
    parameter int RD_LAT      = 1,
    parameter int OPSEL_WIDTH = 5,
    parameter int SEW_WIDTH   = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [VL_WIDTH-1:0]     cmd_vl,
    input  logic [SEW_WIDTH-1:0]    cmd_sew,
    input  logic [OPSEL_WIDTH-1:0]  cmd_opsel,
    input  logic [ADDR_WIDTH-1:0]   cmd_vs2_addr,
    input  logic [ADDR_WIDTH-1:0]   cmd_vd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_scalar,
    output logic                    rf_rd_en,
    output logic [ADDR_WIDTH-1:0]   rf_rd_addr,
    input  logic [DATA_WIDTH-1:0]   rf_rd_data,
    output logic                    red_valid,
    output logic                    red_start,
    output logic                    red_end,
    output logic [DATA_WIDTH-1:0]   red_vec0,
    output logic [DATA_WIDTH-1:0]   red_vec1,
    output logic [OPSEL_WIDTH-1:0]  red_opsel,
    output logic [SEW_WIDTH-1:0]    red_sew,
    output logic [ADDR_WIDTH-1:0]   red_addr,
    input  logic                    red_out_valid,
    input  logic [DATA_WIDTH-1:0]   red_out_vec,
    input  logic [ADDR_WIDTH-1:0]   red_out_addr,
    input  logic [DATA_WIDTH/8-1:0] red_out_be,
    output logic                    wb_valid,
    output logic [DATA_WIDTH-1:0]   wb_data,
    output logic [ADDR_WIDTH-1:0]   wb_addr,
    output logic [DATA_WIDTH/8-1:0] wb_be,
    output logic                    busy,
    output logic                    done
`ifdef VRED_SEQ_PERF_EN
    ,
    input  logic                    perf_clr,
    output logic [31:0]             perf_cmds,
    output logic [31:0]             perf_beats,
    output logic [31:0]             perf_busy_cyc
`endif
);

    state_e                   state_q, state_d;
    logic [SEW_WIDTH-1:0]     sew_q;
    logic [OPSEL_WIDTH-1:0]   opsel_q;
    logic [ADDR_WIDTH-1:0]    vs2_q;
    logic [ADDR_WIDTH-1:0]    vd_q;
    logic [DATA_WIDTH-1:0]    scalar_q;
    logic [VL_WIDTH-1:0]      beats_q;
    logic [VL_WIDTH-1:0]      k_q;
    logic [2:0]               rem_q;

    logic                     accept;
    logic [1:0]               cmd_shift;
    logic [2:0]               cmd_rem;
    logic [VL_WIDTH-1:0]      cmd_beats;
    logic                     issue_first;
    logic                     issue_last;

    logic [RD_LAT-1:0]        vld_p;
    logic [RD_LAT-1:0]        first_p;
    logic [RD_LAT-1:0]        last_p;
    logic [2:0]               rem_p [RD_LAT];

    logic                     a_vld;
    logic                     a_first;
    logic                     a_last;
    logic [63:0]              masked_beat;

    assign accept    = cmd_valid && (state_q == ST_IDLE);
    // Elements per beat is 8 >> sew; the partial-beat remainder decides both
    // the beat count round-up and the tail lanes to mask.
    assign cmd_shift = 2'd3 - cmd_sew;
    assign cmd_rem   = cmd_vl[2:0] & (3'b111 >> cmd_sew);
    assign cmd_beats = (cmd_vl >> cmd_shift) + VL_WIDTH'(cmd_rem != 3'd0);

    assign issue_first = (k_q == '0);
    assign issue_last  = (state_q == ST_ISSUE) && (k_q == beats_q - VL_WIDTH'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (cmd_valid) state_d = (cmd_vl == '0) ? ST_DONE : ST_ISSUE;
            ST_ISSUE: if (issue_last) state_d = ST_WAIT;
            ST_WAIT:  if (wb_valid) state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sew_q    <= '0;
            opsel_q  <= '0;
            vs2_q    <= '0;
            vd_q     <= '0;
            scalar_q <= '0;
            beats_q  <= '0;
            rem_q    <= '0;
            k_q      <= '0;
        end else if (accept) begin
            sew_q    <= cmd_sew;
            opsel_q  <= cmd_opsel;
            vs2_q    <= cmd_vs2_addr;
            vd_q     <= cmd_vd_addr;
            scalar_q <= cmd_scalar;
            beats_q  <= cmd_beats;
            rem_q    <= cmd_rem;
            k_q      <= '0;
        end else if (state_q == ST_ISSUE) begin
            k_q <= k_q + VL_WIDTH'(1);
        end
    end

    assign rf_rd_en   = (state_q == ST_ISSUE);
    assign rf_rd_addr = rf_rd_en ? (vs2_q + ADDR_WIDTH'(k_q)) : '0;

    // Stage p0..p(RD_LAT-1): flags ride alongside the register-file read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p   <= '0;
            first_p <= '0;
            last_p  <= '0;
            for (int i = 0; i < RD_LAT; i++) rem_p[i] <= '0;
        end else begin
            vld_p[0]   <= rf_rd_en;
            first_p[0] <= rf_rd_en && issue_first;
            last_p[0]  <= issue_last;
            rem_p[0]   <= issue_last ? rem_q : 3'd0;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_p[i]   <= vld_p[i-1];
                first_p[i] <= first_p[i-1];
                last_p[i]  <= last_p[i-1];
                rem_p[i]   <= rem_p[i-1];
            end
        end
    end

    assign a_vld   = vld_p[RD_LAT-1];
    assign a_first = first_p[RD_LAT-1];
    assign a_last  = last_p[RD_LAT-1];

    vred_tail_mask u_tail_mask (
        .beat   (rf_rd_data),
        .vl_rem (rem_p[RD_LAT-1]),
        .sew    (sew_q),
        .opsel  (opsel_q),
        .masked (masked_beat)
    );

    // Aligned stage: pipeline beat driven straight from read data.
    assign red_valid = a_vld;
    assign red_start = a_vld && a_first;
    assign red_end   = a_vld && a_last;
    assign red_vec0  = a_vld ? masked_beat : '0;
    assign red_vec1  = (a_vld && a_first) ? scalar_q : '0;
    assign red_opsel = opsel_q;
    assign red_sew   = sew_q;
    assign red_addr  = vd_q;

    // Write-back stage: one-cycle pulse; WAIT leaves for DONE on the next cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_valid <= 1'b0;
            wb_data  <= '0;
            wb_addr  <= '0;
            wb_be    <= '0;
        end else begin
            wb_valid <= (state_q == ST_WAIT) && red_out_valid && !wb_valid;
            if ((state_q == ST_WAIT) && red_out_valid && !wb_valid) begin
                wb_data <= red_out_vec;
                wb_addr <= red_out_addr;
                wb_be   <= red_out_be;
            end
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);

`ifdef VRED_SEQ_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_cmds     <= '0;
            perf_beats    <= '0;
            perf_busy_cyc <= '0;
        end else if (perf_clr) begin
            perf_cmds     <= '0;
            perf_beats    <= '0;
            perf_busy_cyc <= '0;
        end else begin
            if (accept)    perf_cmds     <= perf_cmds + 32'd1;
            if (red_valid) perf_beats    <= perf_beats + 32'd1;
            if (busy)      perf_busy_cyc <= perf_busy_cyc + 32'd1;
        end
    end
`endif

endmodule
